mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Sits between the control unit and the external memory bus.
- Shares one SRAM/ROM bus between the CPU (control unit strobes) and a secondary requester (DMA/video).
- Inserts programmable wait states.
- Drives the control unit's n_mem_rdy stall input.
- Owns mem_n_oe/mem_n_we and the address mux; the data-bus mux is steered externally by dma_sel.

Parameters:
- WAIT_STATES, 1, extra clk cycles per access (0..15); every access lasts WAIT_STATES+1 cycles.
- ADDR_W, 16, address width.
- BURST_LEN, 4, maximum consecutive DMA accesses while the CPU waits (used only with MEM_ARB_BURST_EN).

Ports:
- clk  in  1  system clock; all state changes on posedge
- n_rst  in  1  asynchronous active-low reset
- cpu_n_oe  in  1  CPU read strobe from control unit, active low
- cpu_n_we  in  1  CPU write strobe from control unit, active low
- cpu_addr  in  ADDR_W  CPU address (IP or DP)
- dma_req  in  1  DMA request, level, active high
- dma_we  in  1  DMA direction: 1 = write, 0 = read; sampled at grant
- dma_addr  in  ADDR_W  DMA address; held stable while dma_req is high
- n_mem_rdy  out  1  to control unit; 0 = access complete/no stall, 1 = stall
- dma_sel  out  1  DMA owns the bus (address and data mux select)
- dma_done  out  1  one-cycle pulse in the last cycle of a DMA access
- mem_addr  out  ADDR_W  memory address
- mem_n_oe  out  1  memory output enable, active low
- mem_n_we  out  1  memory write enable, active low

Behaviour:
- CPU request: cpu_req = ~cpu_n_oe | ~cpu_n_we. Both strobes low together is illegal; treat it as a write.
- FSM states: IDLE, CPU_ACC, DMA_ACC. Wait counter cnt is 4 bits. Flag last_dma records the most recent owner.
- Reset, asynchronous: state = IDLE, cnt = 0, last_dma = 1 (CPU wins the first tie), dma_sel = 0, dma_done = 0. Registered strobes are inactive (high).
- Combinational outputs during reset: n_mem_rdy = ~cpu_req, mem_addr = cpu_addr. Reset mid-access aborts immediately; no partial write strobe survives.
- IDLE:
  - mem_addr = cpu_addr; mem_n_oe = mem_n_we = 1.
  - At posedge, a pending request is granted and cnt = WAIT_STATES.
  - Only cpu_req pending -> CPU_ACC. Only dma_req pending -> DMA_ACC.
  - Both pending -> the requester with last_dma indicating it was not served last.
- CPU_ACC:
  - mem_addr = cpu_addr; mem_n_oe = cpu_n_oe.
  - mem_n_we = cpu_n_we only when cnt == 0, giving address setup of WAIT_STATES cycles.
  - cnt decrements each posedge.
  - When cnt == 0: last_dma = 0 and go to IDLE at the next posedge.
- DMA_ACC:
  - dma_sel = 1; mem_addr = dma_addr.
  - mem_n_oe = dma_we (low for reads).
  - mem_n_we = ~dma_we only when cnt == 0.
  - dma_done = 1 when cnt == 0, then last_dma = 1 and go to IDLE.
- n_mem_rdy = cpu_req & ~(state == CPU_ACC & cnt == 0):
  - stalls the CPU in IDLE, during DMA and during wait states;
  - releases for exactly the final cycle of its access.
- A CPU request still asserted after completion is treated as a new access.
  - Back-to-back CPU accesses cost WAIT_STATES+1 cycles each, plus 1 IDLE cycle.
- No CPU strobe in IDLE -> n_mem_rdy = 0, so the control unit never stalls on non-memory microsteps.
- DMA request dropped mid-access: the access still completes; dma_done pulses.
- WAIT_STATES = 0: the access is a single cycle, with a write strobe in that cycle.

Optional Feature:
Macro: MEM_ARB_BURST_EN
- Defined: a 3-bit burst counter bc, reset 0, counts completed DMA accesses.
  - After a DMA access, if dma_req is still high and bc+1 < BURST_LEN, go directly DMA_ACC -> DMA_ACC with cnt reloaded, even while the CPU waits.
  - Otherwise -> IDLE. bc clears on leaving DMA_ACC.
  - dma_done pulses once per access.
- Undefined: strict single-access alternation as above. bc and the BURST_LEN logic are absent.

Test Plan:
1. Reset with cpu_n_oe = 0 -> n_mem_rdy = 1, mem_n_oe = 1, dma_sel = 0. Release n_rst -> CPU_ACC at the first posedge.
2. WAIT_STATES = 1, CPU read at addr 0x1234 -> mem_addr = 0x1234.
   - mem_n_oe low for 2 cycles.
   - n_mem_rdy = 1 in the IDLE cycle and the first access cycle, 0 in the second.
3. WAIT_STATES = 1, CPU write -> mem_n_we low only in the second access cycle; address is stable for 2 cycles.
4. cpu_req and dma_req rise together after reset -> CPU served first, then DMA (dma_sel = 1, mem_addr = dma_addr, dma_done one pulse), then CPU again. Grants strictly alternate.
5. CPU read arrives during a DMA write to 0x8000 -> n_mem_rdy = 1 until the DMA completes; the CPU access follows. mem_n_we asserted only for DMA cnt == 0.
6. MEM_ARB_BURST_EN, BURST_LEN = 4, dma_req held, CPU waiting -> exactly 4 dma_done pulses, then the CPU is granted. n_rst pulsed mid-burst -> outputs idle immediately.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares the SRAM/ROM bus between the CPU strobes and a DMA requester,
// with programmable wait states. Define MEM_ARB_BURST_EN to allow DMA bursts of up to BURST_LEN accesses.
module mem_bus_arbiter #(
   parameter int WAIT_STATES = 1,
   parameter int ADDR_W      = 16
`ifdef MEM_ARB_BURST_EN
   ,
   parameter int BURST_LEN   = 4
`endif
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cpu_n_oe,
   input  logic              cpu_n_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   output logic              n_mem_rdy,
   output logic              dma_sel,
   output logic              dma_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_n_oe,
   output logic              mem_n_we
);

   typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

   localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       last_dma, last_dma_nxt;
   logic       dma_we_r, dma_we_nxt;
   logic       cpu_req, cpu_wr, cnt_zero;
`ifdef MEM_ARB_BURST_EN
   logic [2:0] bc, bc_nxt;
`endif

   assign cpu_req  = ~cpu_n_oe | ~cpu_n_we;
   assign cpu_wr   = ~cpu_n_we;
   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         last_dma <= 1'b1;
         dma_we_r <= 1'b0;
`ifdef MEM_ARB_BURST_EN
         bc       <= '0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         last_dma <= last_dma_nxt;
         dma_we_r <= dma_we_nxt;
`ifdef MEM_ARB_BURST_EN
         bc       <= bc_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      last_dma_nxt = last_dma;
      dma_we_nxt   = dma_we_r;
`ifdef MEM_ARB_BURST_EN
      bc_nxt       = bc;
`endif
      dma_sel      = 1'b0;
      dma_done     = 1'b0;
      mem_addr     = cpu_addr;
      mem_n_oe     = 1'b1;
      mem_n_we     = 1'b1;
      n_mem_rdy    = cpu_req & ~((state == CPU_ACC) & cnt_zero);

      case (state)
         IDLE: begin
            // On a tie, last_dma picks whichever side was not served last
            if (cpu_req && (!dma_req || last_dma)) begin
               state_nxt = CPU_ACC;
               cnt_nxt   = WS_CNT;
            end else if (dma_req) begin
               state_nxt  = DMA_ACC;
               cnt_nxt    = WS_CNT;
               dma_we_nxt = dma_we;
            end
         end
         CPU_ACC: begin
            // Both strobes low is handled as a write: read enable stays off
            mem_n_oe = cpu_n_oe | cpu_wr;
            mem_n_we = cpu_n_we | ~cnt_zero;
            if (cnt_zero) begin
               state_nxt    = IDLE;
               last_dma_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         DMA_ACC: begin
            dma_sel  = 1'b1;
            mem_addr = dma_addr;
            mem_n_oe = dma_we_r;
            mem_n_we = ~dma_we_r | ~cnt_zero;
            if (cnt_zero) begin
               dma_done     = 1'b1;
               last_dma_nxt = 1'b1;
`ifdef MEM_ARB_BURST_EN
               if (dma_req && (int'(bc) + 1 < BURST_LEN)) begin
                  cnt_nxt    = WS_CNT;
                  bc_nxt     = bc + 3'd1;
                  dma_we_nxt = dma_we;
               end else begin
                  state_nxt = IDLE;
                  bc_nxt    = '0;
               end
`else
               state_nxt = IDLE;
`endif
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (WAIT_STATES = 1): per-cycle vector table fed
// through an expected-output queue, plus hand sequences for DMA/CPU contention and reset abort.
module tb_mem_bus_arbiter;

   localparam int AW = 16;
`ifdef MEM_ARB_BURST_EN
   localparam int EXP_DONES = 4;
`else
   localparam int EXP_DONES = 1;
`endif

   logic          clk = 1'b0;
   logic          n_rst, cpu_n_oe, cpu_n_we, dma_req, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
   logic          n_mem_rdy, dma_sel, dma_done, mem_n_oe, mem_n_we;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic          rst;
      logic          oe;
      logic          we;
      logic [AW-1:0] ca;
      logic          dq;
      logic          dw;
      logic [AW-1:0] da;
      logic          rdy;
      logic          sel;
      logic          dn;
      logic [AW-1:0] ma;
      logic          moe;
      logic          mwe;
   } vec_t;

   typedef logic [20:0] obs_t;

   vec_t vecs[$];
   obs_t exp_q[$];

   mem_bus_arbiter #(
`ifdef MEM_ARB_BURST_EN
      .BURST_LEN  (4),
`endif
      .WAIT_STATES(1),
      .ADDR_W     (AW)
   ) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .cpu_n_oe (cpu_n_oe),
      .cpu_n_we (cpu_n_we),
      .cpu_addr (cpu_addr),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .dma_addr (dma_addr),
      .n_mem_rdy(n_mem_rdy),
      .dma_sel  (dma_sel),
      .dma_done (dma_done),
      .mem_addr (mem_addr),
      .mem_n_oe (mem_n_oe),
      .mem_n_we (mem_n_we)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic r, oe, we, input logic [AW-1:0] ca,
                               input logic dq, dw, input logic [AW-1:0] da,
                               input logic rdy, sel, dn, input logic [AW-1:0] ma,
                               input logic moe, mwe);
      vec_t v;
      v = '{rst: r, oe: oe, we: we, ca: ca, dq: dq, dw: dw, da: da,
            rdy: rdy, sel: sel, dn: dn, ma: ma, moe: moe, mwe: mwe};
      return v;
   endfunction

   initial begin
      int   dones;
      int   granted;
      obs_t act;

      n_rst = 1'b0; cpu_n_oe = 1'b1; cpu_n_we = 1'b1;
      dma_req = 1'b0; dma_we = 1'b0; cpu_addr = '0; dma_addr = '0;

      // reset with read strobe low, then first CPU read
      vecs.push_back(mk(0, 0,1,16'h1234, 0,0,16'h8000,  1,0,0,16'h1234, 1,1));
      vecs.push_back(mk(1, 0,1,16'h1234, 0,0,16'h8000,  1,0,0,16'h1234, 1,1));
      vecs.push_back(mk(1, 0,1,16'h1234, 0,0,16'h8000,  1,0,0,16'h1234, 0,1));
      vecs.push_back(mk(1, 0,1,16'h1234, 0,0,16'h8000,  0,0,0,16'h1234, 0,1));
      vecs.push_back(mk(1, 1,1,16'h1234, 0,0,16'h8000,  0,0,0,16'h1234, 1,1));
      // CPU write: strobe only in the final access cycle
      vecs.push_back(mk(1, 1,0,16'h2222, 0,0,16'h8000,  1,0,0,16'h2222, 1,1));
      vecs.push_back(mk(1, 1,0,16'h2222, 0,0,16'h8000,  1,0,0,16'h2222, 1,1));
      vecs.push_back(mk(1, 1,0,16'h2222, 0,0,16'h8000,  0,0,0,16'h2222, 1,0));
      vecs.push_back(mk(1, 1,1,16'h2222, 0,0,16'h8000,  0,0,0,16'h2222, 1,1));
      // both strobes low behaves as a write
      vecs.push_back(mk(1, 0,0,16'h3333, 0,0,16'h8000,  1,0,0,16'h3333, 1,1));
      vecs.push_back(mk(1, 0,0,16'h3333, 0,0,16'h8000,  1,0,0,16'h3333, 1,1));
      vecs.push_back(mk(1, 0,0,16'h3333, 0,0,16'h8000,  0,0,0,16'h3333, 1,0));
      vecs.push_back(mk(1, 1,1,16'h3333, 0,0,16'h8000,  0,0,0,16'h3333, 1,1));
      // reset in the write-strobe cycle kills the strobe at once
      vecs.push_back(mk(1, 1,0,16'h4444, 0,0,16'h8000,  1,0,0,16'h4444, 1,1));
      vecs.push_back(mk(1, 1,0,16'h4444, 0,0,16'h8000,  1,0,0,16'h4444, 1,1));
      vecs.push_back(mk(0, 1,0,16'h4444, 0,0,16'h8000,  1,0,0,16'h4444, 1,1));
      vecs.push_back(mk(1, 1,1,16'h4444, 0,0,16'h8000,  0,0,0,16'h4444, 1,1));
      // simultaneous requests alternate CPU, DMA, CPU, DMA
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  0,0,0,16'h0100, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 0,0,16'h8000,  1,1,0,16'h8000, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 0,0,16'h8000,  1,1,1,16'h8000, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  0,0,0,16'h0100, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 1,0,16'h8000,  1,0,0,16'h0100, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0100, 0,0,16'h8000,  1,1,0,16'h8000, 0,1));
      vecs.push_back(mk(1, 1,1,16'h0100, 0,0,16'h8000,  0,1,1,16'h8000, 0,1));
      vecs.push_back(mk(1, 1,1,16'h0100, 0,0,16'h8000,  0,0,0,16'h0100, 1,1));
      // DMA write with a CPU read arriving mid-access
      vecs.push_back(mk(1, 1,1,16'h0300, 1,1,16'h8000,  0,0,0,16'h0300, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0300, 0,1,16'h8000,  1,1,0,16'h8000, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0300, 0,1,16'h8000,  1,1,1,16'h8000, 1,0));
      vecs.push_back(mk(1, 0,1,16'h0300, 0,1,16'h8000,  1,0,0,16'h0300, 1,1));
      vecs.push_back(mk(1, 0,1,16'h0300, 0,1,16'h8000,  1,0,0,16'h0300, 0,1));
      vecs.push_back(mk(1, 0,1,16'h0300, 0,1,16'h8000,  0,0,0,16'h0300, 0,1));
      vecs.push_back(mk(1, 1,1,16'h0300, 0,1,16'h8000,  0,0,0,16'h0300, 1,1));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         n_rst    = vecs[i].rst;
         cpu_n_oe = vecs[i].oe;
         cpu_n_we = vecs[i].we;
         cpu_addr = vecs[i].ca;
         dma_req  = vecs[i].dq;
         dma_we   = vecs[i].dw;
         dma_addr = vecs[i].da;
         exp_q.push_back({vecs[i].rdy, vecs[i].sel, vecs[i].dn, vecs[i].ma, vecs[i].moe, vecs[i].mwe});
         #2;
         act = {n_mem_rdy, dma_sel, dma_done, mem_addr, mem_n_oe, mem_n_we};
         check($sformatf("vec%0d {rdy,sel,done,addr,oe,we}", i), 32'(act), 32'(exp_q.pop_front()));
      end

      // DMA held high while the CPU waits: count DMA accesses before the CPU completes
      @(negedge clk);
      n_rst = 1'b0; cpu_n_oe = 1'b1; cpu_n_we = 1'b1; dma_req = 1'b0;
      @(negedge clk);
      n_rst = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h9000; cpu_addr = 16'h0500;
      @(negedge clk);
      cpu_n_oe = 1'b0;
      dones = 0;
      granted = 0;
      for (int c = 0; c < 100 && granted == 0; c++) begin
         #2;
         if (dma_done) dones++;
         if (!n_mem_rdy) granted = 1;
         else @(negedge clk);
      end
      check("cpu_granted_after_dma", 32'(granted), 32'd1);
      check("dma_done_count", 32'(dones), 32'(EXP_DONES));
      check("cpu_access_after_dma {addr,oe,sel}", {13'd0, mem_addr, mem_n_oe, dma_sel},
            {13'd0, 16'h0500, 1'b0, 1'b0});

      // reset during a DMA write strobe returns the bus to idle immediately
      @(negedge clk);
      n_rst = 1'b0; cpu_n_oe = 1'b1; dma_req = 1'b0;
      @(negedge clk);
      n_rst = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hA000; cpu_addr = 16'h0600;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("dma_write_strobe", 32'(mem_n_we), 32'd0);
      n_rst = 1'b0;
      #1;
      check("reset_abort {sel,done,oe,we,addr}",
            {12'd0, dma_sel, dma_done, mem_n_oe, mem_n_we, mem_addr},
            {12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0600});
      @(negedge clk);
      n_rst = 1'b1; dma_req = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
